// File: rtl/xain_audio_i2s_if.sv
// Stereo sample input and I2S DAC pin bundle for the Xain'd Sleena audio stage.
// The core side uses master, the serialiser uses slave.
interface xain_audio_i2s_if;
  logic        sample;
  logic [15:0] snd_l;
  logic [15:0] snd_r;
  logic        mute;
  logic        audio_mclk;
  logic        audio_sclk;
  logic        audio_lrck;
  logic        audio_dac;
  logic        frame_load;
  logic [7:0]  overrun_cnt;

  modport master (
    output sample, snd_l, snd_r, mute,
    input  audio_mclk, audio_sclk, audio_lrck, audio_dac, frame_load, overrun_cnt
  );

  modport slave (
    input  sample, snd_l, snd_r, mute,
    output audio_mclk, audio_sclk, audio_lrck, audio_dac, frame_load, overrun_cnt
  );
endinterface

// File: rtl/xain_audio_i2s.sv
// Buffers one stereo pair from the core and serialises it as I2S for the Pocket DAC.
// MCLK/SCLK/LRCK come from a fractional phase accumulator running on clk.
module xain_audio_i2s #(
  parameter int unsigned CLK_HZ  = 49152000,
  parameter int unsigned MCLK_HZ = 12288000,
  parameter int unsigned ACC_W   = 32
) (
  input logic             clk,
  input logic             reset,
  xain_audio_i2s_if.slave snd
);

  // One extra bit so that 2*MCLK_HZ == CLK_HZ still yields a carry on every clk.
  localparam logic [ACC_W:0] INC = (ACC_W + 1)'(
    ((96'd1 << ACC_W) * 96'd2 * 96'(MCLK_HZ) + 96'(CLK_HZ / 2)) / 96'(CLK_HZ));

  // I2S one-bit delay: slot 0 idles, slots 1..16 carry the word MSB first.
  function automatic logic slot_bit(input logic [4:0] slot, input logic [15:0] word);
    logic [3:0] idx;
    idx = 4'(5'd16 - slot);
    if ((slot >= 5'd1) && (slot <= 5'd16)) begin
      slot_bit = word[idx];
    end else begin
      slot_bit = 1'b0;
    end
  endfunction

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   acc_sum_s;
  logic             htick_s;
  logic             fall_s;
  logic             load_s;

  logic             mclk_q, mclk_d;
  logic [2:0]       div_q, div_d;
  logic             sclk_q, sclk_d;
  logic [5:0]       bitcnt_q, bitcnt_d;
  logic             lrck_q, lrck_d;
  logic             dac_q, dac_d;
  logic             frame_load_q, frame_load_d;

  logic [15:0]      hold_l_q, hold_l_d;
  logic [15:0]      hold_r_q, hold_r_d;
  logic             pending_q, pending_d;
  logic [7:0]       overrun_q, overrun_d;
  logic [15:0]      shift_l_q, shift_l_d;
  logic [15:0]      shift_r_q, shift_r_d;

  // Tick generation and the clock divider chain derived from it.
  always_comb begin
    acc_sum_s = {1'b0, acc_q} + INC;
    acc_d     = acc_sum_s[ACC_W-1:0];
    htick_s   = acc_sum_s[ACC_W];
    fall_s    = htick_s && (div_q == 3'd7);
    load_s    = fall_s && (bitcnt_q == 6'd63);

    mclk_d = mclk_q;
    div_d  = div_q;
    if (htick_s) begin
      mclk_d = ~mclk_q;
      div_d  = div_q + 3'd1;
    end else begin
      mclk_d = mclk_q;
      div_d  = div_q;
    end
    sclk_d = div_d[2];
  end

  // Bit counter, word select and serial data, all advanced on SCLK falling events.
  always_comb begin
    bitcnt_d     = bitcnt_q;
    lrck_d       = lrck_q;
    dac_d        = dac_q;
    frame_load_d = load_s;
    if (fall_s) begin
      bitcnt_d = bitcnt_q + 6'd1;
      lrck_d   = bitcnt_d[5];
      dac_d    = slot_bit(bitcnt_d[4:0], bitcnt_d[5] ? shift_r_q : shift_l_q);
    end else begin
      bitcnt_d = bitcnt_q;
      lrck_d   = lrck_q;
      dac_d    = dac_q;
    end
  end

  // Holding register, pending flag and saturating overrun count.
  always_comb begin
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (snd.sample) begin
      hold_l_d  = snd.snd_l;
      hold_r_d  = snd.snd_r;
      pending_d = 1'b1;
      // A strobe landing on the load edge refills a slot that is being emptied.
      if (pending_q && !load_s && (overrun_q != 8'hFF)) begin
        overrun_d = overrun_q + 8'd1;
      end else begin
        overrun_d = overrun_q;
      end
    end else if (load_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Frame load: take the pending pair, replay the last one, or force silence.
  always_comb begin
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    if (load_s) begin
      if (snd.mute) begin
        shift_l_d = 16'h0000;
        shift_r_d = 16'h0000;
      end else if (pending_q) begin
        shift_l_d = hold_l_q;
        shift_r_d = hold_r_q;
      end else begin
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
      end
    end else begin
      shift_l_d = shift_l_q;
      shift_r_d = shift_r_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q        <= '0;
      mclk_q       <= 1'b0;
      div_q        <= 3'd0;
      sclk_q       <= 1'b0;
      bitcnt_q     <= 6'd0;
      lrck_q       <= 1'b0;
      dac_q        <= 1'b0;
      frame_load_q <= 1'b0;
      hold_l_q     <= 16'h0000;
      hold_r_q     <= 16'h0000;
      pending_q    <= 1'b0;
      overrun_q    <= 8'd0;
      shift_l_q    <= 16'h0000;
      shift_r_q    <= 16'h0000;
    end else begin
      acc_q        <= acc_d;
      mclk_q       <= mclk_d;
      div_q        <= div_d;
      sclk_q       <= sclk_d;
      bitcnt_q     <= bitcnt_d;
      lrck_q       <= lrck_d;
      dac_q        <= dac_d;
      frame_load_q <= frame_load_d;
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      shift_l_q    <= shift_l_d;
      shift_r_q    <= shift_r_d;
    end
  end

  assign snd.audio_mclk  = mclk_q;
  assign snd.audio_sclk  = sclk_q;
  assign snd.audio_lrck  = lrck_q;
  assign snd.audio_dac   = dac_q;
  assign snd.frame_load  = frame_load_q;
  assign snd.overrun_cnt = overrun_q;

endmodule

// File: tb/tb_xain_audio_i2s.sv
// Directed bench for xain_audio_i2s: clock ratios, framing, buffering and reset.
module tb_xain_audio_i2s;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  xain_audio_i2s_if aif ();

  xain_audio_i2s dut (
    .clk   (clk),
    .reset (reset),
    .snd   (aif.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       sig = aif.audio_mclk;
      1:       sig = aif.audio_sclk;
      2:       sig = aif.audio_lrck;
      3:       sig = aif.frame_load;
      default: sig = 1'b0;
    endcase
  endfunction

  // Clocks between two consecutive rising edges of the selected output (0 if none).
  task automatic measure(input int sel, output int per);
    logic prev, cur;
    int   start;
    bit   started, done;
    per = 0; start = 0; started = 0; done = 0;
    prev = sig(sel);
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      cur = sig(sel);
      if (cur && !prev) begin
        if (started) begin
          per  = n - start;
          done = 1;
        end else begin
          started = 1;
          start   = n;
        end
      end
      prev = cur;
    end
  endtask

  task automatic wait_frame_load();
    bit seen;
    seen = 0;
    for (int n = 0; n < 1100 && !seen; n++) begin
      @(negedge clk);
      if (aif.frame_load) seen = 1;
    end
    check_eq("fl_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_mclk"}, 32'(aif.audio_mclk),  32'd0);
    check_eq({tag, "_sclk"}, 32'(aif.audio_sclk),  32'd0);
    check_eq({tag, "_lrck"}, 32'(aif.audio_lrck),  32'd0);
    check_eq({tag, "_dac"},  32'(aif.audio_dac),   32'd0);
    check_eq({tag, "_fl"},   32'(aif.frame_load),  32'd0);
    check_eq({tag, "_ovr"},  32'(aif.overrun_cnt), 32'd0);
  endtask

  // Capture 64 slots on SCLK rising edges starting right after a frame load.
  task automatic check_frame(input string tag, input bit already, input logic [15:0] el,
                             input logic [15:0] er);
    logic [63:0] bits, lr;
    logic [15:0] l, r;
    logic        prev;
    int          stray, lr_bad, missed;
    bit          got;
    bits = '0; lr = '0; l = '0; r = '0;
    stray = 0; lr_bad = 0; missed = 0;
    if (!already) wait_frame_load();
    prev = aif.audio_sclk;
    for (int s = 0; s < 64; s++) begin
      got = 0;
      for (int n = 0; n < 40 && !got; n++) begin
        @(negedge clk);
        if (aif.audio_sclk && !prev) got = 1;
        prev = aif.audio_sclk;
      end
      if (!got) missed++;
      bits[s] = aif.audio_dac;
      lr[s]   = aif.audio_lrck;
    end
    for (int s = 1; s <= 16; s++) begin
      l[16-s] = bits[s];
      r[16-s] = bits[32+s];
    end
    for (int s = 0; s < 64; s++) begin
      if (((s % 32) == 0 || (s % 32) > 16) && bits[s]) stray++;
      if (lr[s] != (s >= 32)) lr_bad++;
    end
    check_eq({tag, "_left"},   32'(l), 32'(el));
    check_eq({tag, "_right"},  32'(r), 32'(er));
    check_eq({tag, "_stray"},  32'(stray), 32'd0);
    check_eq({tag, "_lrck"},   32'(lr_bad), 32'd0);
    check_eq({tag, "_sclk"},   32'(missed), 32'd0);
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    aif.sample = 1'b1;
    aif.snd_l  = l;
    aif.snd_r  = r;
    @(negedge clk);
    aif.sample = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int per;
    reset      = 1'b1;
    aif.sample = 1'b0;
    aif.snd_l  = 16'h0000;
    aif.snd_r  = 16'h0000;
    aif.mute   = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("rst");
    reset = 1'b0;

    measure(0, per); check_eq("mclk_period", 32'(per), 32'd4);
    measure(1, per); check_eq("sclk_period", 32'(per), 32'd16);
    measure(2, per); check_eq("lrck_period", 32'(per), 32'd1024);
    measure(3, per); check_eq("fl_period",   32'(per), 32'd1024);

    // Serialisation of extreme patterns.
    wait_frame_load();
    strobe(16'h8001, 16'h7FFE);
    check_frame("ser", 0, 16'h8001, 16'h7FFE);

    // Replay of a single pair over three frames.
    wait_frame_load();
    strobe(16'h1234, 16'h5678);
    check_frame("rep0", 0, 16'h1234, 16'h5678);
    check_frame("rep1", 0, 16'h1234, 16'h5678);
    check_frame("rep2", 0, 16'h1234, 16'h5678);
    check_eq("rep_ovr", 32'(aif.overrun_cnt), 32'd0);

    // Collision: a pending pair, then a new strobe on the load edge itself.
    wait_frame_load();
    strobe(16'h1111, 16'h2222);
    repeat (1022) @(negedge clk);
    aif.sample = 1'b1;
    aif.snd_l  = 16'hA5C3;
    aif.snd_r  = 16'h3C5A;
    @(negedge clk);
    aif.sample = 1'b0;
    check_eq("coll_align", 32'(aif.frame_load), 32'd1);
    check_frame("coll_old", 1, 16'h1111, 16'h2222);
    check_frame("coll_new", 0, 16'hA5C3, 16'h3C5A);
    check_eq("coll_ovr", 32'(aif.overrun_cnt), 32'd0);

    // Mute forces silence at the next load.
    wait_frame_load();
    aif.mute = 1'b1;
    check_frame("mute", 0, 16'h0000, 16'h0000);
    aif.mute = 1'b0;

    // Overrun: 300 strobes in one frame, last one wins.
    wait_frame_load();
    for (int i = 0; i < 300; i++) begin
      aif.sample = 1'b1;
      aif.snd_l  = 16'(i);
      aif.snd_r  = ~16'(i);
      @(negedge clk);
    end
    aif.sample = 1'b0;
    check_eq("ovr_sat", 32'(aif.overrun_cnt), 32'd255);
    check_frame("ovr_last", 0, 16'h012B, 16'hFED4);

    // Asynchronous reset in the middle of slot 8.
    wait_frame_load();
    strobe(16'hFFFF, 16'hFFFF);
    repeat (131) @(negedge clk);
    check_eq("pre_rst_ovr", 32'(aif.overrun_cnt), 32'd255);
    #2 reset = 1'b1;
    #1 check_zero_outputs("arst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_frame("post_rst", 0, 16'h0000, 16'h0000);
    check_eq("post_rst_ovr", 32'(aif.overrun_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xain_audio_i2s.md
Name: xain_audio_i2s

Overview:
- Downstream audio stage of the Xain'd Sleena core.
- Consumes the core's signed 16-bit `snd1`/`snd2` samples and their `sample` strobe.
- Buffers one stereo pair and serialises it onto the Analogue Pocket I2S DAC pins: `audio_mclk`, `audio_sclk`, `audio_lrck`, `audio_dac`.
- All bit clocks are derived from the system clock by a fractional phase accumulator, so the block runs entirely in the core clock domain.

Parameters:
- CLK_HZ, 49152000: frequency of `clk` in Hz.
- MCLK_HZ, 12288000: target MCLK frequency in Hz. SCLK = MCLK/4, LRCK = SCLK/64 (48 kHz at the default).
- ACC_W, 32: phase accumulator width. INC = round(2^ACC_W * 2 * MCLK_HZ / CLK_HZ). Requires 2*MCLK_HZ ≤ CLK_HZ.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- sample  in  1  one-clk strobe: `snd_l`/`snd_r` valid
- snd_l  in  16  signed left sample (`snd1`)
- snd_r  in  16  signed right sample (`snd2`)
- mute  in  1  forces zero data at the next frame load
- audio_mclk  out  1  master clock to the DAC
- audio_sclk  out  1  bit clock
- audio_lrck  out  1  word select; 0 = left
- audio_dac  out  1  serial data, MSB first
- frame_load  out  1  one-clk pulse when a new stereo frame is loaded
- overrun_cnt  out  8  saturating count of samples dropped while a sample was pending

Behaviour:
- Interface (already decided): one clock, `clk`; `reset` is asynchronous and active-high.
- Reset values:
  - all outputs 0;
  - accumulator, divider and bit counter 0;
  - pending flag 0; holding and shift registers 0.
- Tick generation:
  - `acc <= acc + INC` every clk.
  - The carry-out forms a one-clk `htick` (MCLK half-period).
  - `audio_mclk` toggles on each `htick`.
- Divider:
  - 3-bit counter `div` increments on `htick`.
  - `audio_sclk` = `div[2]`, so SCLK = MCLK/4.
  - An SCLK falling event occurs on the `htick` where `div` wraps 7→0.
- Bit counter:
  - 6-bit `bitcnt` increments on each SCLK falling event and wraps 63→0.
  - `audio_lrck` = `bitcnt[5]`, registered and updated on the same event.
- Data slot (I2S, one-bit delay), with slot = `bitcnt[4:0]` after the increment:
  - slot 0 → `audio_dac` = 0;
  - slots 1..16 → `audio_dac` = word[16-slot], where word is left if `lrck`=0, right otherwise;
  - slots 17..31 → 0.
  - `audio_dac` changes only on SCLK falling events.
- Input buffering:
  - `sample`=1 captures `snd_l`/`snd_r` into the holding register and sets `pending`.
  - If `pending` is already 1 when `sample` arrives:
    - the holding register is overwritten with the newer sample;
    - `overrun_cnt` increments, saturating at 255.
- Frame load (on the SCLK falling event where `bitcnt` wraps 63→0):
  - If `pending`: holding → shift registers, `pending` cleared.
  - If not pending: the previous shift words are replayed (no underrun counter).
  - If `mute`: both shift words load 0 regardless of the above; `pending` is still cleared.
  - `frame_load` pulses for 1 clk.
- Simultaneous `sample` and frame load in the same clk:
  - the load takes the old holding contents;
  - the new sample is captured and `pending` stays 1;
  - no overrun is counted for this case.
- Reset mid-frame: all state returns to reset values immediately (async). The first frame after reset transmits zeros until a sample has been loaded.
- Latency: a sample captured before a frame load appears MSB-first on `audio_dac` at slot 1 of that frame.

Test Plan:
- Defaults (INC = 2^31): after reset release, verify:
  - `audio_mclk` toggles every 2 clks;
  - `audio_sclk` period = 16 clks;
  - `audio_lrck` period = 1024 clks;
  - `frame_load` every 1024 clks.
- Serialisation: send `sample` with `snd_l`=16'h8001, `snd_r`=16'h7FFE before a frame load. Captured on SCLK rising edges, expect:
  - left slots 1..16 = 1000000000000001, other left slots = 0;
  - right slots 1..16 = 0111111111111110.
- Replay: single sample 16'h1234/16'h5678, then no further `sample` for 3 frames → the same words are transmitted each frame; `overrun_cnt` = 0.
- Overrun: 300 `sample` strobes within one frame → `overrun_cnt` saturates at 255; the next frame carries the last sample's values.
- Collision/mute:
  - `sample` in the same clk as `frame_load` → that frame carries the prior pair, the following frame the new pair, `overrun_cnt` unchanged.
  - `mute`=1 → all `audio_dac` bits 0 in the next frame.
- Async reset: assert `reset` mid-slot 8 (between clock edges) → all outputs 0 immediately. After release, the first frame is all-zero data.
